hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Producer-side companion to the forwarding unit: detects hazards forwarding cannot resolve.
//  Covers load-use RAW and data-memory wait states.
//  Drives stall/flush/bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
//  Also applies taken-branch flushes and keeps a saturating stall-cycle counter.
// PARAMETERS
//  LU_BUBBLES   1   bubbles inserted per load-use hazard (legal 1..3)
//  MEM_TIMEOUT  15  max consecutive MEM_WAIT cycles before forced release
//  CNT_W        16  width of Stall_Cycles counter
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous reset, active-high
//  Rs1_ID         in   5      rs1 of instruction in ID
//  Rs2_ID         in   5      rs2 of instruction in ID
//  Rs1_Used       in   1      ID instruction reads rs1
//  Rs2_Used       in   1      ID instruction reads rs2
//  Rd_EX          in   5      rd of instruction in EX
//  EX_MemRead     in   1      EX instruction is a load
//  MA_MemReq      in   1      MA instruction accesses data memory
//  MA_MemReady    in   1      data memory completes access this cycle
//  Branch_Taken   in   1      EX resolves taken branch/jump
//  PC_Stall       out  1      hold PC
//  IF_ID_Stall    out  1      hold IF/ID register
//  IF_ID_Flush    out  1      clear IF/ID to NOP
//  ID_EX_Stall    out  1      hold ID/EX register
//  ID_EX_Flush    out  1      load bubble into ID/EX
//  EX_MEM_Stall   out  1      hold EX/MEM register
//  MEM_WB_Flush   out  1      load bubble into MEM/WB
//  Mem_Timeout    out  1      sticky: MEM_WAIT hit MEM_TIMEOUT
//  Stall_Cycles   out  CNT_W  cycles with PC_Stall=1, saturating
// BEHAVIOUR
//  - State register {RUN, LU_STALL, MEM_WAIT}; control outputs are combinational from state+inputs.
//  - While rst=1: all control outputs 0. Next edge: state=RUN, bubble cnt=0, wait cnt=0, Mem_Timeout=0, Stall_Cycles=0.
//  - lu_hit = EX_MemRead & Rd_EX!=0 & ((Rs1_Used & Rs1_ID==Rd_EX) | (Rs2_Used & Rs2_ID==Rd_EX)).
//  - mem_busy = MA_MemReq & ~MA_MemReady.
//  - Priority each cycle: mem_busy > Branch_Taken > lu_hit/LU_STALL.
//  - mem_busy in any state:
//    - PC_Stall = IF_ID_Stall = ID_EX_Stall = EX_MEM_Stall = 1; MEM_WB_Flush = 1; no IF_ID/ID_EX flush.
//    - Goto MEM_WAIT and increment wait cnt.
//    - A pending LU_STALL bubble count is preserved; resume there on exit.
//  - MEM_WAIT exit when MA_MemReady=1:
//    - That cycle no freeze, MEM_WB_Flush=0; wait cnt cleared.
//    - Next state = LU_STALL if bubbles remain, else RUN.
//  - MEM_WAIT timeout: if wait cnt reaches MEM_TIMEOUT with MA_MemReady still 0, then on that cycle:
//    - Release the freeze and set Mem_Timeout=1 until rst.
//    - Treat the access as completed; continue as on a normal exit.
//  - Branch_Taken (no mem_busy):
//    - IF_ID_Flush = ID_EX_Flush = 1, PC not stalled.
//    - Cancel any lu_hit or remaining bubbles; next state RUN.
//  - Branch_Taken held during MEM_WAIT is acted on in the first unfrozen cycle.
//  - RUN with lu_hit: PC_Stall = IF_ID_Stall = 1, ID_EX_Flush = 1.
//    - LU_BUBBLES=1: stay RUN.
//    - Else goto LU_STALL with remaining = LU_BUBBLES-1.
//  - LU_STALL: PC_Stall = IF_ID_Stall = ID_EX_Flush = 1; decrement remaining; at 0 goto RUN.
//    - lu_hit is not re-evaluated here.
//  - Stall_Cycles += 1 on every edge where PC_Stall=1 and rst=0; holds at 2^CNT_W-1.
//  - Rd_EX==0 never causes a stall.
//  - Stall and flush of the same register are never both 1.
// TESTING
//  - Reset: rst=1 for 2 cycles with lu_hit inputs active -> all outputs 0, Stall_Cycles=0.
//  - Load-use: EX_MemRead=1, Rd_EX=5, Rs2_ID=5, Rs2_Used=1 ->
//    - PC_Stall/IF_ID_Stall/ID_EX_Flush=1 for exactly LU_BUBBLES cycles; Stall_Cycles +LU_BUBBLES.
//  - x0 / unused operand: Rd_EX=0 = Rs1_ID, or Rs1_Used=0 with Rs1_ID==Rd_EX -> no stall.
//  - Mem wait: MA_MemReq=1, MA_MemReady=0 for 3 cycles then 1 ->
//    - Full freeze + MEM_WB_Flush for 3 cycles, released on the ready cycle.
//  - Branch during LU_STALL (LU_BUBBLES=3): Branch_Taken on 2nd bubble ->
//    - IF_ID_Flush = ID_EX_Flush = 1, PC_Stall=0, state RUN next cycle.
//  - Timeout: MA_MemReady held 0 ->
//    - Freeze ends on the cycle wait cnt reaches 15; Mem_Timeout=1 stays until rst.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubbles, data-memory wait freezes with a
// watchdog release, taken-branch flushes, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
   parameter int unsigned LU_BUBBLES  = 1,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1_ID,
   input  logic [4:0]       Rs2_ID,
   input  logic             Rs1_Used,
   input  logic             Rs2_Used,
   input  logic [4:0]       Rd_EX,
   input  logic             EX_MemRead,
   input  logic             MA_MemReq,
   input  logic             MA_MemReady,
   input  logic             Branch_Taken,
   output logic             PC_Stall,
   output logic             IF_ID_Stall,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Stall,
   output logic             ID_EX_Flush,
   output logic             EX_MEM_Stall,
   output logic             MEM_WB_Flush,
   output logic             Mem_Timeout,
   output logic [CNT_W-1:0] Stall_Cycles
);

   localparam int unsigned         WAIT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [1:0]          LU_REM   = 2'(LU_BUBBLES - 1);
   localparam logic [WAIT_W-1:0]   WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_e;

   state_e             state_q, state_d;
   logic [1:0]         bub_q, bub_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               tmo_q, tmo_d;
   logic [CNT_W-1:0]   cnt_q;

   logic lu_hit, mem_busy, tmo_hit;
   logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush;

   assign lu_hit   = EX_MemRead & (Rd_EX != 5'd0) &
                     ((Rs1_Used & (Rs1_ID == Rd_EX)) | (Rs2_Used & (Rs2_ID == Rd_EX)));
   assign mem_busy = MA_MemReq & ~MA_MemReady;
   assign tmo_hit  = (state_q == MEM_WAIT) & mem_busy & (wait_q >= WAIT_MAX);

   always_comb begin
      state_d     = state_q;
      bub_d       = bub_q;
      wait_d      = wait_q;
      tmo_d       = tmo_q;
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_stall  = 1'b0;
      idex_flush  = 1'b0;
      exmem_stall = 1'b0;
      memwb_flush = 1'b0;

      if (mem_busy && !tmo_hit) begin
         // Full freeze; remaining load-use bubbles stay parked in bub_q.
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_stall  = 1'b1;
         exmem_stall = 1'b1;
         memwb_flush = 1'b1;
         wait_d      = wait_q + 1'b1;
         state_d     = MEM_WAIT;
      end else if (state_q == MEM_WAIT) begin
         wait_d = '0;
         if (tmo_hit) tmo_d = 1'b1;
         if (Branch_Taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            bub_d      = '0;
            state_d    = RUN;
         end else begin
            state_d = (bub_q != 2'd0) ? LU_STALL : RUN;
         end
      end else if (Branch_Taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         bub_d      = '0;
         state_d    = RUN;
      end else if (state_q == LU_STALL) begin
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
         idex_flush = 1'b1;
         bub_d      = bub_q - 1'b1;
         if (bub_q <= 2'd1) state_d = RUN;
      end else if (lu_hit) begin
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
         idex_flush = 1'b1;
         if (LU_BUBBLES > 1) begin
            bub_d   = LU_REM;
            state_d = LU_STALL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         bub_q   <= '0;
         wait_q  <= '0;
         tmo_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bub_q   <= bub_d;
         wait_q  <= wait_d;
         tmo_q   <= tmo_d;
         if (pc_stall && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign PC_Stall     = pc_stall    & ~rst;
   assign IF_ID_Stall  = ifid_stall  & ~rst;
   assign IF_ID_Flush  = ifid_flush  & ~rst;
   assign ID_EX_Stall  = idex_stall  & ~rst;
   assign ID_EX_Flush  = idex_flush  & ~rst;
   assign EX_MEM_Stall = exmem_stall & ~rst;
   assign MEM_WB_Flush = memwb_flush & ~rst;
   assign Mem_Timeout  = tmo_q       & ~rst;
   assign Stall_Cycles = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: one instance with single-bubble load-use
// and a narrow counter, one with three bubbles and the default counter width.
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1, rs2, rd;
   logic       u1, u2, emr, req, rdy, br;

   logic [7:0]  o1, o3;
   logic [3:0]  cnt1;
   logic [15:0] cnt3;

   int n_checks = 0;
   int n_errors = 0;

   // Output packing: {PC_S, IFID_S, IFID_F, IDEX_S, IDEX_F, EXMEM_S, MEMWB_F, TMO}
   localparam logic [7:0] NONE = 8'b0000_0000;
   localparam logic [7:0] LU   = 8'b1100_1000;
   localparam logic [7:0] FRZ  = 8'b1101_0110;
   localparam logic [7:0] BR   = 8'b0010_1000;
   localparam logic [7:0] TMO  = 8'b0000_0001;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.LU_BUBBLES(1), .MEM_TIMEOUT(15), .CNT_W(4)) d1 (
      .clk(clk), .rst(rst), .Rs1_ID(rs1), .Rs2_ID(rs2), .Rs1_Used(u1), .Rs2_Used(u2),
      .Rd_EX(rd), .EX_MemRead(emr), .MA_MemReq(req), .MA_MemReady(rdy), .Branch_Taken(br),
      .PC_Stall(o1[7]), .IF_ID_Stall(o1[6]), .IF_ID_Flush(o1[5]), .ID_EX_Stall(o1[4]),
      .ID_EX_Flush(o1[3]), .EX_MEM_Stall(o1[2]), .MEM_WB_Flush(o1[1]), .Mem_Timeout(o1[0]),
      .Stall_Cycles(cnt1));

   hazard_stall_ctrl #(.LU_BUBBLES(3), .MEM_TIMEOUT(15), .CNT_W(16)) d3 (
      .clk(clk), .rst(rst), .Rs1_ID(rs1), .Rs2_ID(rs2), .Rs1_Used(u1), .Rs2_Used(u2),
      .Rd_EX(rd), .EX_MemRead(emr), .MA_MemReq(req), .MA_MemReady(rdy), .Branch_Taken(br),
      .PC_Stall(o3[7]), .IF_ID_Stall(o3[6]), .IF_ID_Flush(o3[5]), .ID_EX_Stall(o3[4]),
      .ID_EX_Flush(o3[3]), .EX_MEM_Stall(o3[2]), .MEM_WB_Flush(o3[1]), .Mem_Timeout(o3[0]),
      .Stall_Cycles(cnt3));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic set_in(input logic e, input logic [4:0] d, input logic [4:0] s1, input logic a1,
                         input logic [4:0] s2, input logic a2, input logic rq, input logic rd_y,
                         input logic b);
      emr = e; rd = d; rs1 = s1; u1 = a1; rs2 = s2; u2 = a2; req = rq; rdy = rd_y; br = b;
   endtask

   task automatic clr();
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Check outputs mid-cycle, then advance past the next rising edge.
   task automatic cyc(input string tag, input logic [7:0] e1, input logic [7:0] e3);
      @(negedge clk);
      check({tag, "/lu1"}, 32'(o1), 32'(e1));
      check({tag, "/lu3"}, 32'(o3), 32'(e3));
      @(posedge clk);
      #1;
   endtask

   task automatic cnt(input string tag, input int c1, input int c3);
      check({tag, "/cnt1"}, 32'(cnt1), c1);
      check({tag, "/cnt3"}, 32'(cnt3), c3);
   endtask

   initial begin
      // Reset with a load-use pattern present
      rst = 1'b1;
      set_in(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("rst0", NONE, NONE);
      cyc("rst1", NONE, NONE);
      cnt("rst", 0, 0);
      rst = 1'b0;
      clr();
      cyc("idle", NONE, NONE);
      cnt("idle", 0, 0);

      // Load-use via rs2
      set_in(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("lu_a", LU, LU);
      clr();
      cyc("lu_b", NONE, LU);
      cyc("lu_c", NONE, LU);
      cyc("lu_d", NONE, NONE);
      cnt("lu", 1, 3);

      // x0 destination, unused operand, then a real rs1 hazard
      set_in(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("x0", NONE, NONE);
      set_in(1'b1, 5'd7, 5'd7, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("unused", NONE, NONE);
      set_in(1'b1, 5'd7, 5'd7, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("rs1_a", LU, LU);
      clr();
      cyc("rs1_b", NONE, LU);
      cyc("rs1_c", NONE, LU);
      cyc("rs1_d", NONE, NONE);
      cnt("rs1", 2, 6);

      // Memory wait of 3 cycles
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc("mw_frz", FRZ, FRZ);
      rdy = 1'b1;
      cyc("mw_rdy", NONE, NONE);
      clr();
      cyc("mw_after", NONE, NONE);
      cnt("mw", 5, 9);

      // Branch on second bubble
      set_in(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("brl_a", LU, LU);
      clr();
      br = 1'b1;
      cyc("brl_br", BR, BR);
      clr();
      cyc("brl_run", NONE, NONE);
      cnt("brl", 6, 10);

      // Memory wait in the middle of a load-use stall keeps remaining bubbles
      set_in(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("pres_a", LU, LU);
      clr();
      req = 1'b1;
      cyc("pres_f0", FRZ, FRZ);
      cyc("pres_f1", FRZ, FRZ);
      rdy = 1'b1;
      cyc("pres_rdy", NONE, NONE);
      clr();
      cyc("pres_b1", NONE, LU);
      cyc("pres_b2", NONE, LU);
      cyc("pres_run", NONE, NONE);
      cnt("pres", 9, 15);

      // Branch held across a memory wait
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc("brw_frz", FRZ, FRZ);
      rdy = 1'b1;
      cyc("brw_rel", BR, BR);
      clr();
      cyc("brw_run", NONE, NONE);
      cnt("brw", 10, 16);

      // Watchdog: 15 frozen cycles, release on the 16th, sticky flag; narrow counter saturates
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) cyc("tmo_frz", FRZ, FRZ);
      cyc("tmo_rel", NONE, NONE);
      clr();
      cyc("tmo_st0", TMO, TMO);
      cyc("tmo_st1", TMO, TMO);
      cnt("tmo", 15, 31);

      // Reset clears the sticky flag and the counters
      rst = 1'b1;
      cyc("rst2", NONE, NONE);
      rst = 1'b0;
      cyc("post", NONE, NONE);
      cnt("post", 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
